// File: rtl/altusoc_gpio_pkg.sv
// altusoc_gpio_pkg: register map, AXI responses and FSM states for the GPIO responder.
package altusoc_gpio_pkg;
    localparam logic [7:0] GPIO_OUT_OFF  = 8'h00;
    localparam logic [7:0] GPIO_IN_OFF   = 8'h04;
    localparam logic [7:0] GPIO_EN_OFF   = 8'h08;
    localparam logic [7:0] GPIO_STAT_OFF = 8'h0C;
    localparam logic [7:0] GPIO_SET_OFF  = 8'h10;
    localparam logic [7:0] GPIO_CLR_OFF  = 8'h14;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [1:0] RESP_SLVERR   = 2'b10;
    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_RESP} rstate_t;
    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction
endpackage

// File: rtl/altusoc_sync2.sv
// altusoc_sync2: two-flop synchronizer for asynchronous GPIO inputs.
module altusoc_sync2 #(
    parameter int W = 4
) (
    input  logic         mclk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] s1;
    always_ff @(posedge mclk or negedge rst_n)
        if (!rst_n) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
endmodule

// File: rtl/altusoc_gpio_axil.sv
// altusoc_gpio_axil: AXI4-Lite GPIO responder with output register, synchronized
// inputs and a sticky rising-edge interrupt.
module altusoc_gpio_axil #(
    parameter int                GPIO_W    = 4,
    parameter logic [GPIO_W-1:0] OUT_RESET = '0
) (
    input  logic              mclk,
    input  logic              rst_n,
    input  logic              awvalid,
    output logic              awready,
    input  logic [7:0]        awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    input  logic              arvalid,
    output logic              arready,
    input  logic [7:0]        araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    input  logic [GPIO_W-1:0] i_gpio,
    output logic [GPIO_W-1:0] o_gpio,
    output logic              o_irq
);
    import altusoc_gpio_pkg::*;

    wstate_t ws_q, ws_n;
    rstate_t rs_q, rs_n;
    logic live, w_fire, r_fire, w_ok, r_ok, unused;
    logic [7:0] wa, ra;
    logic [31:0] mask, rd;
    logic [GPIO_W-1:0] bm, wm, out_q, out_n, en_q, en_n, stat_q, stat_n, w1c, in_s, prev;

    altusoc_sync2 #(.W(GPIO_W)) u_sync (.mclk(mclk), .rst_n(rst_n), .d(i_gpio), .q(in_s));

    assign wa      = {awaddr[7:2], 2'b00};
    assign ra      = {araddr[7:2], 2'b00};
    assign mask    = strb_mask(wstrb);
    assign bm      = mask[GPIO_W-1:0];
    assign wm      = wdata[GPIO_W-1:0] & bm;
    assign unused  = ^{awaddr[1:0], araddr[1:0], wdata, mask};
    assign o_gpio  = out_q;
    assign stat_n  = (stat_q & ~w1c) | (in_s & ~prev);

    // live holds the ready outputs low until the first edge after reset release
    always_comb begin
        w_fire  = live && ws_q == W_IDLE && awvalid && wvalid;
        awready = w_fire;
        wready  = w_fire;
        bvalid  = ws_q == W_RESP;
        ws_n    = ws_q == W_IDLE ? (w_fire ? W_RESP : W_IDLE) : (bready ? W_IDLE : W_RESP);
        arready = live && rs_q == R_IDLE;
        r_fire  = arready && arvalid;
        rvalid  = rs_q == R_RESP;
        rs_n    = rs_q == R_IDLE ? (r_fire ? R_RESP : R_IDLE) : (rready ? R_IDLE : R_RESP);
    end

    always_comb begin
        out_n = out_q;
        en_n  = en_q;
        w1c   = '0;
        w_ok  = 1'b1;
        if (w_fire)
            case (wa)
                GPIO_OUT_OFF:  out_n = (out_q & ~bm) | wm;
                GPIO_IN_OFF:   ;
                GPIO_EN_OFF:   en_n = (en_q & ~bm) | wm;
                GPIO_STAT_OFF: w1c = wm;
                GPIO_SET_OFF:  out_n = out_q | wm;
                GPIO_CLR_OFF:  out_n = out_q & ~wm;
                default:       w_ok = 1'b0;
            endcase
    end

    always_comb begin
        rd   = '0;
        r_ok = 1'b1;
        case (ra)
            GPIO_OUT_OFF:  rd[GPIO_W-1:0] = out_q;
            GPIO_IN_OFF:   rd[GPIO_W-1:0] = in_s;
            GPIO_EN_OFF:   rd[GPIO_W-1:0] = en_q;
            GPIO_STAT_OFF: rd[GPIO_W-1:0] = stat_q;
            GPIO_SET_OFF:  ;
            GPIO_CLR_OFF:  ;
            default:       r_ok = 1'b0;
        endcase
    end

    always_ff @(posedge mclk or negedge rst_n)
        if (!rst_n) begin
            live   <= 1'b0;
            ws_q   <= W_IDLE;
            rs_q   <= R_IDLE;
            bresp  <= RESP_OKAY;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
            out_q  <= OUT_RESET;
            en_q   <= '0;
            stat_q <= '0;
            prev   <= '0;
            o_irq  <= 1'b0;
        end else begin
            live   <= 1'b1;
            ws_q   <= ws_n;
            rs_q   <= rs_n;
            if (w_fire) bresp <= w_ok ? RESP_OKAY : RESP_SLVERR;
            if (r_fire) begin
                rdata <= rd;
                rresp <= r_ok ? RESP_OKAY : RESP_SLVERR;
            end
            out_q  <= out_n;
            en_q   <= en_n;
            stat_q <= stat_n;
            prev   <= in_s;
            o_irq  <= |(stat_n & en_q);
        end
endmodule

// File: tb/tb_altusoc_gpio_axil.sv
// tb_altusoc_gpio_axil: directed-vector bench for the GPIO responder with o_gpio[3:1]
// looped back onto i_gpio[3:1] and i_gpio[0] tied high (or pins driven directly).
module tb_altusoc_gpio_axil;
    logic mclk = 0, rst_n = 0;
    logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic awready, wready, bvalid, arready, rvalid, o_irq;
    logic [7:0] awaddr = 0, araddr = 0;
    logic [31:0] wdata = 0, rdata;
    logic [3:0] wstrb = 0, o_gpio, i_gpio, drv = 0;
    logic [1:0] bresp, rresp;
    logic loop = 1;
    int vectors = 0, miscompares = 0;

    assign i_gpio = loop ? {o_gpio[3:1], 1'b1} : drv;

    altusoc_gpio_axil #(.GPIO_W(4), .OUT_RESET(4'h0)) dut (
        .mclk(mclk), .rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .i_gpio(i_gpio), .o_gpio(o_gpio), .o_irq(o_irq)
    );

    always #5 mclk = ~mclk;

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
        int n = 0;
        @(negedge mclk);
        awvalid = 1; wvalid = 1; awaddr = a; wdata = d; wstrb = s; bready = 1;
        while (!awready && n < 20) begin @(negedge mclk); n++; end
        vectors++;
        if (!awready) begin
            miscompares++;
            $display("FAIL write_accept @%h: awready %b required 1", a, awready);
        end
        @(posedge mclk); #1 awvalid = 0; wvalid = 0;
        @(negedge mclk);
        n = 0;
        while (!bvalid && n < 20) begin @(negedge mclk); n++; end
        r = bresp;
        @(posedge mclk); #1 bready = 0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        @(negedge mclk);
        arvalid = 1; araddr = a; rready = 1;
        while (!arready && n < 20) begin @(negedge mclk); n++; end
        vectors++;
        if (!arready) begin
            miscompares++;
            $display("FAIL read_accept @%h: arready %b required 1", a, arready);
        end
        @(posedge mclk); #1 arvalid = 0;
        @(negedge mclk);
        n = 0;
        while (!rvalid && n < 20) begin @(negedge mclk); n++; end
        d = rdata; r = rresp;
        @(posedge mclk); #1 rready = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r;
        repeat (2) @(negedge mclk);
        vectors++;
        if (o_gpio !== 4'h0 || o_irq !== 0 || bvalid !== 0 || rvalid !== 0 || awready !== 0 || arready !== 0) begin
            miscompares++;
            $display("FAIL reset_outputs: gpio=%h irq=%b bv=%b rv=%b awr=%b arr=%b required 0 0 0 0 0 0",
                     o_gpio, o_irq, bvalid, rvalid, awready, arready);
        end
        rst_n = 1;
        repeat (4) @(negedge mclk);
        axi_read(8'h04, d, r);
        vectors++;
        if (d !== 32'h1 || r !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_in_read: rdata=%h rresp=%b required 00000001 00", d, r);
        end
    endtask

    task automatic test_out_write();
        logic [31:0] d; logic [1:0] r;
        axi_write(8'h00, 32'hA, 4'hF, r);
        vectors++;
        if (r !== 2'b00 || o_gpio !== 4'hA) begin
            miscompares++;
            $display("FAIL out_write: bresp=%b gpio=%h required 00 a", r, o_gpio);
        end
        repeat (3) @(negedge mclk);
        axi_read(8'h04, d, r);
        vectors++;
        if (d !== 32'hB || r !== 2'b00) begin
            miscompares++;
            $display("FAIL loopback_in: rdata=%h rresp=%b required 0000000b 00", d, r);
        end
        axi_read(8'h00, d, r);
        vectors++;
        if (d !== 32'hA) begin
            miscompares++;
            $display("FAIL out_readback: rdata=%h required 0000000a", d);
        end
    endtask

    task automatic test_set_clr();
        logic [31:0] d; logic [1:0] r;
        axi_write(8'h10, 32'h5, 4'hF, r);
        vectors++;
        if (o_gpio !== 4'hF || r !== 2'b00) begin
            miscompares++;
            $display("FAIL out_set: gpio=%h bresp=%b required f 00", o_gpio, r);
        end
        axi_write(8'h14, 32'h8, 4'hF, r);
        vectors++;
        if (o_gpio !== 4'h7 || r !== 2'b00) begin
            miscompares++;
            $display("FAIL out_clr: gpio=%h bresp=%b required 7 00", o_gpio, r);
        end
        axi_read(8'h10, d, r);
        vectors++;
        if (d !== 0 || r !== 2'b00) begin
            miscompares++;
            $display("FAIL set_read: rdata=%h rresp=%b required 0 00", d, r);
        end
        axi_read(8'h14, d, r);
        vectors++;
        if (d !== 0 || r !== 2'b00) begin
            miscompares++;
            $display("FAIL clr_read: rdata=%h rresp=%b required 0 00", d, r);
        end
        axi_write(8'h00, 32'hF, 4'hE, r);
        vectors++;
        if (o_gpio !== 4'h7) begin
            miscompares++;
            $display("FAIL strobe_mask: gpio=%h required 7", o_gpio);
        end
    endtask

    task automatic test_irq();
        logic [31:0] d; logic [1:0] r;
        loop = 0; drv = 4'b0001;
        repeat (5) @(negedge mclk);
        axi_write(8'h0C, 32'hF, 4'hF, r);
        axi_read(8'h0C, d, r);
        vectors++;
        if (d !== 0) begin
            miscompares++;
            $display("FAIL status_clear_all: rdata=%h required 0", d);
        end
        axi_write(8'h08, 32'h2, 4'hF, r);
        @(negedge mclk); drv = 4'b0011;
        @(negedge mclk);
        @(negedge mclk);
        vectors++;
        if (o_irq !== 0) begin
            miscompares++;
            $display("FAIL irq_early: o_irq=%b required 0", o_irq);
        end
        @(negedge mclk);
        vectors++;
        if (o_irq !== 1) begin
            miscompares++;
            $display("FAIL irq_rise: o_irq=%b required 1", o_irq);
        end
        drv = 4'b0111;
        repeat (4) @(negedge mclk);
        axi_read(8'h0C, d, r);
        vectors++;
        if (d !== 32'h6 || o_irq !== 1) begin
            miscompares++;
            $display("FAIL status_sticky: rdata=%h irq=%b required 00000006 1", d, o_irq);
        end
        axi_write(8'h0C, 32'h6, 4'hF, r);
        vectors++;
        if (o_irq !== 0) begin
            miscompares++;
            $display("FAIL irq_w1c: o_irq=%b required 0", o_irq);
        end
        axi_read(8'h0C, d, r);
        vectors++;
        if (d !== 0) begin
            miscompares++;
            $display("FAIL status_w1c: rdata=%h required 0", d);
        end
        drv = 4'b0101;
        repeat (4) @(negedge mclk);
        drv = 4'b0111;
        @(negedge mclk);
        @(negedge mclk);
        awvalid = 1; wvalid = 1; awaddr = 8'h0C; wdata = 32'h2; wstrb = 4'hF; bready = 1;
        @(posedge mclk); #1 awvalid = 0; wvalid = 0;
        @(negedge mclk);
        vectors++;
        if (bvalid !== 1 || bresp !== 2'b00) begin
            miscompares++;
            $display("FAIL coincident_resp: bvalid=%b bresp=%b required 1 00", bvalid, bresp);
        end
        @(posedge mclk); #1 bready = 0;
        axi_read(8'h0C, d, r);
        vectors++;
        if (d !== 32'h2 || o_irq !== 1) begin
            miscompares++;
            $display("FAIL set_wins: rdata=%h irq=%b required 00000002 1", d, o_irq);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge mclk);
        awvalid = 1; wvalid = 1; awaddr = 8'h00; wdata = 32'h9; wstrb = 4'hF; bready = 0;
        @(posedge mclk); #1 wdata = 32'h3;
        repeat (5) begin
            @(negedge mclk);
            vectors++;
            if (bvalid !== 1 || bresp !== 2'b00 || awready !== 0 || o_gpio !== 4'h9) begin
                miscompares++;
                $display("FAIL b_stall: bvalid=%b bresp=%b awready=%b gpio=%h required 1 00 0 9",
                         bvalid, bresp, awready, o_gpio);
            end
        end
        bready = 1;
        @(posedge mclk); #1;
        @(negedge mclk);
        vectors++;
        if (bvalid !== 0 || awready !== 1 || o_gpio !== 4'h9) begin
            miscompares++;
            $display("FAIL b_release: bvalid=%b awready=%b gpio=%h required 0 1 9", bvalid, awready, o_gpio);
        end
        @(posedge mclk); #1 awvalid = 0; wvalid = 0;
        @(negedge mclk);
        vectors++;
        if (bvalid !== 1 || o_gpio !== 4'h3) begin
            miscompares++;
            $display("FAIL second_write: bvalid=%b gpio=%h required 1 3", bvalid, o_gpio);
        end
        @(posedge mclk); #1 bready = 0;
        @(negedge mclk);
        arvalid = 1; araddr = 8'h00; rready = 0;
        @(posedge mclk); #1 arvalid = 0;
        repeat (5) begin
            @(negedge mclk);
            vectors++;
            if (rvalid !== 1 || rdata !== 32'h3 || rresp !== 2'b00 || arready !== 0) begin
                miscompares++;
                $display("FAIL r_stall: rvalid=%b rdata=%h rresp=%b arready=%b required 1 00000003 00 0",
                         rvalid, rdata, rresp, arready);
            end
        end
        rready = 1;
        @(posedge mclk); #1 rready = 0;
        @(negedge mclk);
        vectors++;
        if (rvalid !== 0 || arready !== 1) begin
            miscompares++;
            $display("FAIL r_release: rvalid=%b arready=%b required 0 1", rvalid, arready);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d; logic [1:0] r;
        axi_write(8'h20, 32'hF, 4'hF, r);
        vectors++;
        if (r !== 2'b10 || o_gpio !== 4'h3) begin
            miscompares++;
            $display("FAIL unmapped_write: bresp=%b gpio=%h required 10 3", r, o_gpio);
        end
        axi_read(8'h08, d, r);
        vectors++;
        if (d !== 32'h2 || r !== 2'b00) begin
            miscompares++;
            $display("FAIL unmapped_no_effect: irq_en=%h rresp=%b required 00000002 00", d, r);
        end
        axi_read(8'h3C, d, r);
        vectors++;
        if (d !== 0 || r !== 2'b10) begin
            miscompares++;
            $display("FAIL unmapped_read: rdata=%h rresp=%b required 0 10", d, r);
        end
    endtask

    initial begin
        test_reset();
        test_out_write();
        test_set_clr();
        test_irq();
        test_back_to_back();
        test_unmapped();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/altusoc_gpio_axil.md
Name: altusoc_gpio_axil

Overview:
- Memory-mapped GPIO responder inside altusoc_core, on the AXI4-Lite peripheral fabric.
- Drives the o_gpio pins and samples the i_gpio pins through a synchronizer.
- Raises a level interrupt on enabled rising edges of the inputs.
- This is the SoC-side endpoint for the pins that the system bench drives and observes (loopback of o_gpio[3:1] onto i_gpio[3:1], i_gpio[0] tied high).

Parameters:
- GPIO_W, 4, number of GPIO bits (1..32).
- OUT_RESET, 0, reset value of the OUT register (GPIO_W bits).

Ports:
- mclk  in  1  clock.
- rst_n  in  1  reset: asynchronous assert, active-low.
- awvalid/awready  in/out  1/1  write address handshake.
- awaddr  in  8  write byte address.
- wvalid/wready  in/out  1/1  write data handshake.
- wdata  in  32  write data.
- wstrb  in  4  byte strobes.
- bvalid/bready  out/in  1/1  write response handshake.
- bresp  out  2  write response.
- arvalid/arready  in/out  1/1  read address handshake.
- araddr  in  8  read byte address.
- rvalid/rready  out/in  1/1  read response handshake.
- rdata  out  32  read data.
- rresp  out  2  read response.
- i_gpio  in  GPIO_W  asynchronous input pins.
- o_gpio  out  GPIO_W  output pins.
- o_irq  out  1  level interrupt; high while (STATUS & IRQ_EN) is non-zero.

Behaviour:
- Reset values:
  - awready=wready=arready=0.
  - bvalid=rvalid=0, bresp=rresp=0, rdata=0.
  - o_gpio=OUT_RESET, o_irq=0.
  - Synchronizer flops=0, previous-sample flop=0.
  - All registers 0 except OUT.
- Register map (word offsets; address bits [1:0] ignored):
  - 0x00 OUT: RW, drives o_gpio directly from the flop, no combinational path from the bus.
  - 0x04 IN: RO, synchronized input value.
  - 0x08 IRQ_EN: RW, per-bit rising-edge enable.
  - 0x0C STATUS: W1C, per-bit sticky rising-edge flag.
  - 0x10 OUT_SET: WO, OUT |= wdata; reads 0.
  - 0x14 OUT_CLR: WO, OUT &= ~wdata; reads 0.
  - Bits above GPIO_W read 0 and are ignored on write.
- Strobes: wstrb is applied per byte for OUT, IRQ_EN and STATUS. The set/clear/W1C mask is wdata AND the strobe-expanded mask.
- Unmapped offsets: writes have no effect and bresp=2'b10 (SLVERR); reads return rdata=0 with rresp=2'b10. Mapped accesses return 2'b00.
- Write FSM (W_IDLE, W_RESP):
  - W_IDLE: awready=wready=1 only when awvalid&&wvalid are both high in the same cycle. The write is performed in that cycle.
  - AW without W (or W without AW) waits in W_IDLE with no acceptance.
  - Next cycle: bvalid=1, state W_RESP.
  - W_RESP: hold bvalid/bresp until bready, then return to W_IDLE. No new write is accepted in that same cycle.
  - Register update is visible on o_gpio 1 cycle after the handshake cycle.
- Read FSM (R_IDLE, R_RESP):
  - R_IDLE: arready=1.
  - On arvalid, register rdata/rresp at that edge; rvalid=1 next cycle.
  - R_RESP: hold stable until rready, then return to R_IDLE.
  - Read latency is 1 cycle. Reads and writes are independent and may complete in the same cycle.
- Input path: two-flop synchronizer (sync1 -> sync2 = IN), then a previous-sample flop.
  - rise = sync2 & ~prev.
  - A pin change appears in IN 2 cycles after the first sampling edge.
  - STATUS sets 1 cycle after that (3 cycles total).
- STATUS update: next = (STATUS & ~w1c_mask) | rise.
  - If a rise and a W1C on the same bit coincide, set wins.
  - Edges are detected regardless of IRQ_EN; IRQ_EN only gates o_irq.
- o_irq is registered: o_irq = |(STATUS_next & IRQ_EN).
- Reset mid-transaction: any outstanding B/R response is dropped. The master must re-issue after reset.

Decomposition:
- Package altusoc_gpio_pkg holds:
  - Register offset constants (GPIO_OUT_OFF..GPIO_CLR_OFF).
  - AXI response constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10).
  - FSM state typedefs for write and read.
- One sub-module, altusoc_sync2: GPIO_W-wide two-flop synchronizer with mclk and rst_n, reset to 0.

Test Plan:
- Reset: with rst_n low, o_gpio=OUT_RESET (0), o_irq=0, bvalid=rvalid=0. Read 0x04 after release with i_gpio=4'b0001 -> rdata=0x1, rresp=0.
- Write 0x00=0xA with wstrb=0xF -> bresp=0. o_gpio=4'hA one cycle after the handshake. With loopback, reading 0x04 >=3 cycles later returns 0xB.
- OUT_SET 0x5 then OUT_CLR 0x8 starting from 0xA -> o_gpio goes 0xF then 0x7. Reads of 0x10/0x14 return 0.
- IRQ: IRQ_EN=0x2, drive i_gpio[1] 0->1 -> STATUS=0x2 and o_irq=1 within 3 cycles. W1C 0x2 -> o_irq=0. An edge coincident with the W1C leaves STATUS[1]=1.
- Backpressure: hold bready=0 for 5 cycles -> bvalid stays high with bresp stable and awready=0. Same for rready with rdata stable.
- Unmapped: write 0x20 -> bresp=2'b10 and no register changes. Read 0x3C -> rdata=0, rresp=2'b10.
